// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_pkg
// Purpose  : Shared constants for the general register file and the ALU
//            datapath that consumes its operands.
// Contents : DATA_W / ADDR_W / NUM_REGS sizing, REG_ZERO index, and the
//            format string used by the simulation write trace.
// Revision : 1.0 - initial release
// ============================================================================
package grf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  // The index space must cover the register array exactly.
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Write trace consumed by the grading harness: PC, destination index, data.
  localparam string TRACE_FMT = "@%h: $%d <= %h";

endpackage : grf_pkg
`default_nettype wire

// File: rtl/grf_if.sv
`default_nettype none
// ============================================================================
// Module   : grf_if
// Purpose  : Bundle of the register-file access signals between the
//            datapath (master) and the register file (slave).
// Signals  : we, a3, wd, pc  - writeback request (pc is trace-only)
//            a1, a2          - read indices (rs / rt)
//            rd1, rd2        - read data feeding ALU operands A / B
// Revision : 1.0 - initial release
// ============================================================================
interface grf_if;
  import grf_pkg::*;

  logic              we;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd;
  logic [31:0]       pc;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (
    output we, a1, a2, a3, wd, pc,
    input  rd1, rd2
  );

  modport slave (
    input  we, a1, a2, a3, wd, pc,
    output rd1, rd2
  );

endinterface : grf_if
`default_nettype wire

// File: rtl/grf_read_port.sv
`default_nettype none
// ============================================================================
// Module   : grf_read_port
// Purpose  : One combinational read port of the register file: index mux,
//            forced zero for $0 and, optionally, write-through forwarding.
// Ports    : addr      - read index
//            regs_flat - register contents, reg i at [i*DATA_W +: DATA_W]
//            we, a3, wd, reset - current writeback request (forwarding only)
//            rd        - read data
// Config   : GRF_BYPASS_EN - when defined, a same-cycle write to the
//            addressed register is forwarded to rd combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module grf_read_port
  import grf_pkg::*;
(
  input  wire logic [ADDR_W-1:0]          addr,
  input  wire logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  wire logic                       we,
  input  wire logic [ADDR_W-1:0]          a3,
  input  wire logic [DATA_W-1:0]          wd,
  input  wire logic                       reset,
  output logic      [DATA_W-1:0]          rd
);

  logic [DATA_W-1:0] w_stored;

  assign w_stored = regs_flat[addr*DATA_W +: DATA_W];

`ifdef GRF_BYPASS_EN
  logic w_fwd;

  // A write that is being dropped (reset) or aimed at $0 must not forward.
  assign w_fwd = we && !reset && (a3 == addr) && (a3 != REG_ZERO);

  always_comb begin
    rd = '0;
    if (w_fwd) begin
      rd = wd;
    end else if (addr != REG_ZERO) begin
      rd = w_stored;
    end
  end
`else
  // Writeback inputs only matter for forwarding; tie them off here.
  logic w_unused_wb;
  assign w_unused_wb = &{1'b0, we, a3, wd, reset};

  always_comb begin
    rd = '0;
    if (addr != REG_ZERO) begin
      rd = w_stored;
    end
  end
`endif

endmodule : grf_read_port
`default_nettype wire

// File: rtl/grf.sv
`default_nettype none
// ============================================================================
// Module   : grf
// Purpose  : 32 x 32-bit general register file upstream of the ALU.
//            Synchronous write, combinational dual read, $0 hardwired to 0.
// Ports    : clk   - system clock, all updates on posedge
//            reset - synchronous active-high clear of every register
//            bus   - grf_if.slave (we/a1/a2/a3/wd/pc in, rd1/rd2 out)
// Config   : GRF_BYPASS_EN - enables write-through forwarding in the read
//            ports (see grf_read_port).
// Trace    : every accepted write (reset low, we high, including a3 == 0)
//            prints PC, index and data in simulation builds only.
// Revision : 1.0 - initial release
// ============================================================================
module grf
  import grf_pkg::*;
(
  input wire logic clk,
  input wire logic reset,
  grf_if.slave     bus
);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;

  // Reset wins over a write in the same cycle; writes to $0 are discarded
  // so r_regs[0] stays zero from the first reset onwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.we && (bus.a3 != REG_ZERO)) begin
      r_regs[bus.a3] <= bus.wd;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end
  endgenerate

  grf_read_port u_rd1 (
    .addr      (bus.a1),
    .regs_flat (w_regs_flat),
    .we        (bus.we),
    .a3        (bus.a3),
    .wd        (bus.wd),
    .reset     (reset),
    .rd        (bus.rd1)
  );

  grf_read_port u_rd2 (
    .addr      (bus.a2),
    .regs_flat (w_regs_flat),
    .we        (bus.we),
    .a3        (bus.a3),
    .wd        (bus.wd),
    .reset     (reset),
    .rd        (bus.rd2)
  );

`ifndef SYNTHESIS
  // Simulation-only write trace; no hardware effect.
  always_ff @(posedge clk) begin
    if (!reset && bus.we) begin
      $display("%s", $sformatf(TRACE_FMT, bus.pc, bus.a3, bus.wd));
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = &{1'b0, bus.pc};
`endif

endmodule : grf
`default_nettype wire

// File: tb/tb_grf.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf
// Purpose  : Self-checking bench for grf. Directed vector table, hand-written
//            corner sequences and a randomized run against an array-based
//            reference model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf;
  import grf_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  grf_if bus();

  grf u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of register contents.
  logic [31:0] m [32];

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Value the model says a read port shows while the given write is pending.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic w,
                                           input logic [4:0] wa, input logic [31:0] d,
                                           input logic r);
    if (a == 0) return 32'h0;
`ifdef GRF_BYPASS_EN
    if (w && !r && wa == a) return d;
`endif
    return m[a];
  endfunction

  // Apply one clock with the given write request, then update the model.
  task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] d, input logic [31:0] p);
    reset  = r;
    bus.we = w;
    bus.a3 = wa;
    bus.wd = d;
    bus.pc = p;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
    end else if (w && wa != 0) begin
      m[wa] = d;
    end
    reset  = 1'b0;
    bus.we = 1'b0;
    bus.a3 = $urandom;
    bus.wd = $urandom;
    bus.pc = $urandom;
  endtask

  task automatic read(input logic [4:0] x1, input logic [4:0] x2,
                      output logic [31:0] r1, output logic [31:0] r2);
    bus.a1 = x1;
    bus.a2 = x2;
    #1;
    r1 = bus.rd1;
    r2 = bus.rd2;
  endtask

  initial begin
    logic [31:0] r1, r2;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] d;
    logic        w, r;

    pass_cnt  = 0;
    total_cnt = 0;
    reset  = 1'b0;
    bus.we = 1'b0;
    bus.a1 = '0;
    bus.a2 = '0;
    bus.a3 = '0;
    bus.wd = '0;
    bus.pc = '0;

    vecs[0] = '{1'b1, 5'd8,  32'h0000_1234, 5'd8,  5'd8,  32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd8,  32'h0,         32'h0000_1234};
    vecs[2] = '{1'b0, 5'd4,  32'd99,        5'd4,  5'd4,  32'h0,         32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'h8000_0000, 5'd31, 5'd0,  32'h8000_0000, 32'h0};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[5] = '{1'b1, 5'd8,  32'hCAFE_F00D, 5'd8,  5'd1,  32'hCAFE_F00D, 32'h0000_0001};
    vecs[6] = '{1'b0, 5'd8,  32'h0,         5'd8,  5'd8,  32'hCAFE_F00D, 32'hCAFE_F00D};

    @(posedge clk);
    #1;

    // 1. Write reg5, reset, then every index reads zero on both ports.
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_2000);
    read(5'd5, 5'd5, r1, r2);
    check("pre_reset_reg5", r1, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read(5'(i), 5'(31 - i), r1, r2);
      check("reset_rd1", r1, 32'h0);
      check("reset_rd2", r2, 32'h0);
    end

    // 2/3/6. Directed vector table: write, then read next cycle.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, vecs[i].we, vecs[i].a3, vecs[i].wd, 32'h0000_3000 + 32'(i*4));
      read(vecs[i].a1, vecs[i].a2, r1, r2);
      check($sformatf("vec%0d_rd1", i), r1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), r2, vecs[i].exp2);
    end

    // 4. Reset priority over a same-cycle write.
    cycle(1'b0, 1'b1, 5'd3, 32'h0000_0055, 32'h0);
    cycle(1'b1, 1'b1, 5'd3, 32'd7, 32'h0000_4000);
    read(5'd3, 5'd3, r1, r2);
    check("rst_prio_rd1", r1, 32'h0);
    check("rst_prio_rd2", r2, 32'h0);

    // 5. Same-cycle read-after-write on reg9.
    cycle(1'b0, 1'b1, 5'd9, 32'd1, 32'h0);
    bus.a1 = 5'd9;
    bus.a2 = 5'd9;
    bus.we = 1'b1;
    bus.a3 = 5'd9;
    bus.wd = 32'hA5A5_A5A5;
    #1;
`ifdef GRF_BYPASS_EN
    check("raw_before_edge", bus.rd1, 32'hA5A5_A5A5);
`else
    check("raw_before_edge", bus.rd1, 32'd1);
`endif
    cycle(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 32'h0000_5000);
    read(5'd9, 5'd9, r1, r2);
    check("raw_after_edge", r1, 32'hA5A5_A5A5);

    // 6. WE=0 hold on a nonzero register, dual-port identical reads.
    cycle(1'b0, 1'b1, 5'd4, 32'h0000_0044, 32'h0);
    cycle(1'b0, 1'b0, 5'd4, 32'd99, 32'h0);
    read(5'd4, 5'd4, r1, r2);
    check("hold_rd1", r1, 32'h0000_0044);
    check("hold_rd2", r2, 32'h0000_0044);

    // Randomized traffic: check reads before each edge against the model.
    for (int n = 0; n < 400; n++) begin
      ra1 = $urandom;
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
      wa  = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
      d   = $urandom;
      w   = $urandom_range(0, 1) == 1;
      r   = $urandom_range(0, 40) == 0;
      reset  = r;
      bus.we = w;
      bus.a3 = wa;
      bus.wd = d;
      bus.a1 = ra1;
      bus.a2 = ra2;
      #1;
      check("rand_rd1", bus.rd1, exp_read(ra1, w, wa, d, r));
      check("rand_rd2", bus.rd2, exp_read(ra2, w, wa, d, r));
      cycle(r, w, wa, d, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_grf
`default_nettype wire
